// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: round-robin arbiter that time-shares one bit-serial
// adder among N requesters. A granted operand pair is shifted LSB-first into
// the adder over W cycles, the returned sum bits are reassembled, and the
// W-bit result is presented on a single response channel tagged with the
// requester's index.
module serial_add_scheduler #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [N*W-1:0]     req_a,
    input  logic [N*W-1:0]     req_b,
    output logic [N-1:0]       req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [W-1:0]       resp_sum,
    output logic [IDW-1:0]     resp_id,
    output logic               sa_vld,
    output logic               sa_a,
    output logic               sa_b,
    output logic               sa_last,
    input  logic               sa_sum
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_r;
    logic [W-1:0]   op_a, op_b;
    logic [W-1:0]   sum_r;
    logic [CW-1:0]  bit_cnt;

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;

    // Round-robin search: first valid requester at or after rr_ptr+1 (mod N).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % N);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the control-side outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        sa_vld     = 1'b0;
        sa_last    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so no acceptance pulse escapes while held in reset.
                if (grant_any && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = SHIFT;
                end
            end
            SHIFT: begin
                sa_vld  = 1'b1;
                sa_last = (bit_cnt == LAST_BIT);
                if (bit_cnt == LAST_BIT) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial operand bits; forced low outside SHIFT so the adder sees clean zeros.
    assign sa_a = sa_vld & op_a[bit_cnt];
    assign sa_b = sa_vld & op_b[bit_cnt];

    assign resp_sum = sum_r;
    assign resp_id  = id_r;

    // Operand latch on grant, bit counter, and sum reassembly during SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= IDW'(N - 1);
            id_r    <= '0;
            op_a    <= '0;
            op_b    <= '0;
            sum_r   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a    <= req_a[int'(grant_idx)*W +: W];
                        op_b    <= req_b[int'(grant_idx)*W +: W];
                        id_r    <= grant_idx;
                        rr_ptr  <= grant_idx;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // The adder's sum is combinational on the bits driven this cycle.
                    sum_r[bit_cnt] <= sa_sum;
                    if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler: a behavioural serial adder closes the loop,
// a transaction-level model predicts every output each cycle, and directed
// scenarios pin grant order, latency, backpressure and reset behaviour.
module tb_serial_add_scheduler;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           resp_ready = 1'b1;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [W-1:0]   resp_sum;
    logic [IDW-1:0] resp_id;
    logic           sa_vld, sa_a, sa_b, sa_last, sa_sum;

    serial_add_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id),
        .sa_vld(sa_vld), .sa_a(sa_a), .sa_b(sa_b), .sa_last(sa_last),
        .sa_sum(sa_sum)
    );

    always #5 clk = ~clk;

    // Bit-serial adder: combinational sum, carry cleared by last or reset.
    logic carry;
    always @(posedge clk or posedge rst) begin
        if (rst)         carry <= 1'b0;
        else if (sa_vld) carry <= sa_last ? 1'b0 : ((sa_a & sa_b) | (sa_a & carry) | (sa_b & carry));
    end
    assign sa_sum = sa_a ^ sa_b ^ carry;

    int errs = 0, checks = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Transaction model: ph=0 waiting, 1..W shifting bit ph-1, W+1 holding result.
    int           ph = 0, m_ptr = N - 1, m_id = 0, m_g;
    logic [W-1:0] m_a = '0, m_b = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 1; i <= N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; m_ptr = N - 1; m_id = 0;
        end else if (ph == 0) begin
            m_g = pick(req_valid, m_ptr);
            if (m_g >= 0) begin
                m_ptr = m_g; m_id = m_g;
                m_a = req_a[m_g*W +: W];
                m_b = req_b[m_g*W +: W];
                ph = 1;
            end
        end else if (ph <= W) begin
            ph++;
        end else if (resp_ready) begin
            ph = 0;
        end
    end

    // Observation queues for the directed checks.
    int           g_id[$], g_cyc[$], r_rise[$], r_id[$], r_cyc[$];
    logic [W-1:0] r_sum[$];
    int           vld_cnt = 0, last_cyc = -1, stall_cnt = 0, stall_rdy = 0, stall_vld = 0;
    logic         prv_rv = 1'b0;

    logic [N-1:0] er;
    logic [W-1:0] sh, es;
    logic         ev, ea, eb, el, erv;
    int           eg;

    // Per-cycle compare against the model, then record events.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_sa_vld", 32'(sa_vld), 0);
            chk("rst_sa_a", 32'(sa_a), 0);
            chk("rst_sa_b", 32'(sa_b), 0);
            chk("rst_sa_last", 32'(sa_last), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_sum", 32'(resp_sum), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            prv_rv = 1'b0;
        end else begin
            er = '0;
            if (ph == 0) begin
                eg = pick(req_valid, m_ptr);
                if (eg >= 0) er = N'(1) << eg;
            end
            ev = (ph >= 1 && ph <= W);
            ea = 1'b0; eb = 1'b0;
            if (ev) begin
                sh = m_a >> (ph - 1); ea = sh[0];
                sh = m_b >> (ph - 1); eb = sh[0];
            end
            el  = (ph == W);
            erv = (ph == W + 1);
            es  = m_a + m_b;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("sa_vld", 32'(sa_vld), 32'(ev));
            chk("sa_a", 32'(sa_a), 32'(ea));
            chk("sa_b", 32'(sa_b), 32'(eb));
            chk("sa_last", 32'(sa_last), 32'(el));
            chk("resp_valid", 32'(resp_valid), 32'(erv));
            if (erv) begin
                chk("resp_sum", 32'(resp_sum), 32'(es));
                chk("resp_id", 32'(resp_id), 32'(m_id));
            end
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
            if (sa_vld) vld_cnt++;
            if (sa_last) last_cyc = cyc;
            if (resp_valid && !prv_rv) r_rise.push_back(cyc);
            if (resp_valid && resp_ready) begin
                r_sum.push_back(resp_sum); r_id.push_back(int'(resp_id)); r_cyc.push_back(cyc);
            end
            if (resp_valid && !resp_ready) begin
                stall_cnt++;
                if (req_ready != '0) stall_rdy++;
                if (sa_vld) stall_vld++;
            end
            prv_rv = resp_valid;
        end
    end

    // Stimulus helpers.
    logic [N-1:0] hold = '0;
    logic         rand_mode = 1'b0;
    logic         s_rv = 1'b0;

    task automatic tick();
        logic [N-1:0] sr;
        @(negedge clk);
        sr   = req_ready;
        s_rv = resp_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(sr & ~hold);
        if (rand_mode) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            resp_ready = ($urandom_range(9) < 7);
        end
    endtask

    task automatic clr();
        g_id.delete(); g_cyc.delete(); r_rise.delete(); r_sum.delete(); r_id.delete(); r_cyc.delete();
        vld_cnt = 0; last_cyc = -1; stall_cnt = 0; stall_rdy = 0; stall_vld = 0;
    endtask

    task automatic wait_grant(input int n, input int budget);
        int k = 0;
        while (g_id.size() < n && k < budget) begin tick(); k++; end
        if (g_id.size() < n) timeout_fail("wait_grant");
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (r_sum.size() < n && k < budget) begin tick(); k++; end
        if (r_sum.size() < n) timeout_fail("wait_resp");
    endtask

    task automatic drain();
        int k = 0;
        while ((req_valid != '0 || ph != 0) && k < 400) begin tick(); k++; end
        if (k >= 400) timeout_fail("drain");
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        // Reset state is checked by the compare process while rst is high.
        repeat (3) tick();
        rst = 1'b0;

        // Single request: 0x35 + 0x4A from requester 2.
        clr();
        set_req(2, 8'h35, 8'h4A);
        wait_resp(1, 40);
        chk("t1_grant_id", 32'(g_id[0]), 2);
        chk("t1_sum", 32'(r_sum[0]), 32'h7F);
        chk("t1_id", 32'(r_id[0]), 2);
        chk("t1_resp_latency", 32'(r_rise[0] - g_cyc[0]), 9);
        chk("t1_vld_cycles", 32'(vld_cnt), 8);
        chk("t1_last_offset", 32'(last_cyc - g_cyc[0]), 8);
        chk("t1_grant_pulses", 32'(g_id.size()), 1);

        // Wrap-around followed by a back-to-back operation.
        drain(); clr();
        set_req(0, 8'hFF, 8'h01);
        wait_grant(1, 20);
        set_req(0, 8'h01, 8'h01);
        wait_resp(2, 60);
        chk("t2_wrap_sum", 32'(r_sum[0]), 32'h00);
        chk("t2_next_sum", 32'(r_sum[1]), 32'h02);
        chk("t2_b2b_spacing", 32'(g_cyc[1] - g_cyc[0]), 10);

        // Fairness from a fresh reset with all requesters held valid.
        drain();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        clr();
        set_req(0, 8'h11, 8'h22);
        set_req(1, 8'h80, 8'h80);
        set_req(2, 8'hF0, 8'h20);
        set_req(3, 8'h7F, 8'h01);
        hold = '1;
        wait_grant(5, 80);
        hold = '0;
        wait_resp(4, 40);
        for (int i = 0; i < 5; i++) chk("t3_grant_order", 32'(g_id[i]), 32'(i % N));
        for (int i = 0; i < 4; i++) chk("t3_grant_spacing", 32'(g_cyc[i+1] - g_cyc[i]), 10);
        chk("t3_sum0", 32'(r_sum[0]), 32'h33);
        chk("t3_sum1", 32'(r_sum[1]), 32'h00);
        chk("t3_sum2", 32'(r_sum[2]), 32'h10);
        chk("t3_sum3", 32'(r_sum[3]), 32'h80);
        for (int i = 0; i < 4; i++) chk("t3_resp_id", 32'(r_id[i]), 32'(i));

        // Backpressure: five stalled cycles in RESP with another request pending.
        drain(); clr();
        resp_ready = 1'b1;
        set_req(1, 8'h12, 8'h34);
        wait_grant(1, 20);
        resp_ready = 1'b0;
        set_req(3, 8'h10, 8'h20);
        begin
            int k = 0;
            s_rv = 1'b0;
            while (!s_rv && k < 20) begin tick(); k++; end
            if (!s_rv) timeout_fail("t4_resp_valid");
        end
        repeat (4) tick();
        resp_ready = 1'b1;
        wait_grant(2, 20);
        wait_resp(2, 40);
        chk("t4_stall_cycles", 32'(stall_cnt), 5);
        chk("t4_stall_ready", 32'(stall_rdy), 0);
        chk("t4_stall_vld", 32'(stall_vld), 0);
        chk("t4_regrant_gap", 32'(g_cyc[1] - r_cyc[0]), 1);
        chk("t4_sum", 32'(r_sum[0]), 32'h46);
        chk("t4_id", 32'(r_id[0]), 1);
        chk("t4_next_id", 32'(g_id[1]), 3);

        // Reset during bit 3 of a carry-heavy operation; requests stay pending.
        drain(); clr();
        set_req(2, 8'hFF, 8'h01);
        set_req(3, 8'h03, 8'h05);
        hold = 4'b0100;
        wait_grant(1, 20);
        chk("t5_pre_grant", 32'(g_id[0]), 2);
        repeat (3) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        hold = '0;
        clr();
        wait_resp(2, 60);
        chk("t5_regrant_first", 32'(g_id[0]), 2);
        chk("t5_regrant_second", 32'(g_id[1]), 3);
        chk("t5_sum_a", 32'(r_sum[0]), 32'h00);
        chk("t5_sum_b", 32'(r_sum[1]), 32'h08);

        // Priority rotation after a grant to 3: requester 1 goes before 3.
        drain(); clr();
        set_req(3, 8'h40, 8'h40);
        set_req(1, 8'h01, 8'h02);
        wait_resp(2, 60);
        chk("t6_first", 32'(g_id[0]), 1);
        chk("t6_second", 32'(g_id[1]), 3);
        chk("t6_sum1", 32'(r_sum[0]), 32'h03);
        chk("t6_sum3", 32'(r_sum[1]), 32'h80);

        // Randomized traffic and backpressure, checked every cycle by the model.
        drain(); clr();
        rand_mode = 1'b1;
        repeat (400) tick();
        rand_mode = 1'b0;
        resp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
